// File: rtl/eth_fcs_engine.sv
// -----------------------------------------------------------------------------
// eth_fcs_engine
//
// Frame-aware Ethernet CRC-32 engine (reflected polynomial 0xEDB88320) that
// sniffs a byte-lane stream beside the MAC. It starts at DA after SFD and
// works in two modes. In generate mode it reports the FCS to append. In check
// mode it validates a received FCS by checking the CRC residue. It also
// tracks frame length, runt frames, illegal keep patterns and good/bad frame
// statistics.
//
// Parameters
//   DATA_W   stream width in bits (8, 16, 32 or 64)
//   MIN_LEN  minimum legal frame length in bytes, FCS included (0 = no check)
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   s_valid     beat qualifier; every valid beat is consumed
//   s_data      beat data; lane 0 (bits 7:0) is first on the wire
//   s_keep      byte enables, contiguous from lane 0
//   s_last      last beat of the frame
//   chk_mode    0 = generate, 1 = check; latched on the first beat of a frame
//   abort       discard the current frame
//   cnt_clr     clear good/bad statistics counters
//   crc_cur     running CRC register before final inversion
//   res_valid   one-cycle result strobe, one cycle after the last beat
//   fcs         ~final CRC; fcs[7:0] goes on the wire first
//   fcs_ok      check mode: residue matched; generate mode: always 1
//   runt        frame shorter than MIN_LEN
//   keep_err    an illegal keep pattern was seen in the frame
//   frame_len   frame byte count, saturating at 0xFFFF
//   good_cnt    frames with fcs_ok & !runt & !keep_err, saturating
//   bad_cnt     all other completed frames, saturating
// -----------------------------------------------------------------------------
module eth_fcs_engine #(
    parameter int DATA_W  = 8,
    parameter int MIN_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    input  logic                chk_mode,
    input  logic                abort,
    input  logic                cnt_clr,
    output logic [31:0]         crc_cur,
    output logic                res_valid,
    output logic [31:0]         fcs,
    output logic                fcs_ok,
    output logic                runt,
    output logic                keep_err,
    output logic [15:0]         frame_len,
    output logic [31:0]         good_cnt,
    output logic [31:0]         bad_cnt
);

    localparam int NB = DATA_W / 8;

    localparam logic [31:0]   CRC_SEED    = 32'hFFFF_FFFF;
    localparam logic [31:0]   CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0]   CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [NB-1:0] KEEP_ALL    = '1;
    localparam logic [NB-1:0] KEEP_ONE    = NB'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    // Fold one byte into the CRC, LSB first.
    function automatic logic [31:0] crc_fold_byte(input logic [31:0] crc_in,
                                                  input logic [7:0]  data_byte);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < 8; b++) begin
            c = (c >> 1) ^ ({32{c[0] ^ data_byte[b]}} & CRC_POLY);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [31:0] crc_reg;
    logic [15:0] len_reg;
    logic        kerr_reg;
    logic        mode_reg;

    logic        res_valid_reg;
    logic [31:0] fcs_reg;
    logic        fcs_ok_reg;
    logic        runt_reg;
    logic        keep_err_reg;
    logic [15:0] frame_len_reg;
    logic [31:0] good_reg;
    logic [31:0] bad_reg;

    // -------------------------------------------------------------------------
    // Lane extraction
    // -------------------------------------------------------------------------
    logic [7:0] lane_byte [NB];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_byte[gi] = s_data[gi*8 +: 8];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Keep decode: effective keep is the lowest contiguous run of set bits.
    // A legal keep is already such a run starting at lane 0, so this only
    // changes anything for malformed beats (which raise keep_err anyway).
    // -------------------------------------------------------------------------
    logic [NB-1:0] eff_keep;
    logic [3:0]    eff_cnt;

    always_comb begin : keep_decode
        logic seen;
        logic brk;
        seen     = 1'b0;
        brk      = 1'b0;
        eff_keep = '0;
        eff_cnt  = 4'd0;
        for (int i = 0; i < NB; i++) begin
            if (s_keep[i] && !brk) begin
                eff_keep[i] = 1'b1;
                eff_cnt     = eff_cnt + 4'd1;
            end
            // A clear lane after the run has started ends the run for good.
            if (seen && !s_keep[i]) begin
                brk = 1'b1;
            end
            seen = seen | s_keep[i];
        end
    end

    logic last_keep_ok;
    logic beat_kerr;

    // Last-beat keep must be 2^n-1 with n >= 1; earlier beats must be full.
    assign last_keep_ok = (s_keep != '0) && ((s_keep & (s_keep + KEEP_ONE)) == '0);
    assign beat_kerr    = s_last ? ~last_keep_ok : (s_keep != KEEP_ALL);

    // -------------------------------------------------------------------------
    // Datapath. A frame start uses the seed and zeroed accumulators directly,
    // so a frame may begin on the cycle right after the previous s_last.
    // -------------------------------------------------------------------------
    logic        in_idle;
    logic [31:0] crc_base;
    logic [15:0] len_base;
    logic        kerr_base;
    logic        mode_cur;
    logic [31:0] crc_acc;
    logic [16:0] len_sum;
    logic [15:0] len_next;
    logic        kerr_next;
    logic [16:0] min_len_w;
    logic        fin_ok;
    logic        fin_runt;
    logic        fin_good;
    logic        frame_end;

    assign in_idle   = (state_reg == ST_IDLE);
    assign crc_base  = in_idle ? CRC_SEED : crc_reg;
    assign len_base  = in_idle ? 16'd0 : len_reg;
    assign kerr_base = in_idle ? 1'b0 : kerr_reg;
    assign mode_cur  = in_idle ? chk_mode : mode_reg;

    always_comb begin : crc_chain
        crc_acc = crc_base;
        for (int i = 0; i < NB; i++) begin
            if (eff_keep[i]) begin
                crc_acc = crc_fold_byte(crc_acc, lane_byte[i]);
            end
        end
    end

    assign len_sum   = {1'b0, len_base} + {13'd0, eff_cnt};
    assign len_next  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign kerr_next = kerr_base | beat_kerr;

    assign min_len_w = 17'(MIN_LEN);
    assign fin_ok    = mode_cur ? (crc_acc == CRC_RESIDUE) : 1'b1;
    assign fin_runt  = ({1'b0, len_next} < min_len_w);
    assign fin_good  = fin_ok & ~fin_runt & ~kerr_next;
    assign frame_end = s_valid & s_last & ~abort;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else if (s_valid) begin
            state_next = s_last ? ST_IDLE : ST_IN_FRAME;
        end
    end

    // -------------------------------------------------------------------------
    // Frame accumulators and results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg       <= CRC_SEED;
            len_reg       <= 16'd0;
            kerr_reg      <= 1'b0;
            mode_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
            fcs_reg       <= 32'd0;
            fcs_ok_reg    <= 1'b0;
            runt_reg      <= 1'b0;
            keep_err_reg  <= 1'b0;
            frame_len_reg <= 16'd0;
        end else begin
            res_valid_reg <= 1'b0;
            if (abort) begin
                crc_reg  <= CRC_SEED;
                len_reg  <= 16'd0;
                kerr_reg <= 1'b0;
            end else if (s_valid) begin
                crc_reg  <= crc_acc;
                len_reg  <= len_next;
                kerr_reg <= kerr_next;
                if (in_idle) begin
                    mode_reg <= chk_mode;
                end
                if (s_last) begin
                    res_valid_reg <= 1'b1;
                    fcs_reg       <= ~crc_acc;
                    fcs_ok_reg    <= fin_ok;
                    runt_reg      <= fin_runt;
                    keep_err_reg  <= kerr_next;
                    frame_len_reg <= len_next;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Statistics; a clear beats a coincident increment.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            good_reg <= 32'd0;
            bad_reg  <= 32'd0;
        end else if (frame_end) begin
            if (fin_good) begin
                if (good_reg != 32'hFFFF_FFFF) begin
                    good_reg <= good_reg + 32'd1;
                end
            end else begin
                if (bad_reg != 32'hFFFF_FFFF) begin
                    bad_reg <= bad_reg + 32'd1;
                end
            end
        end
    end

    assign crc_cur   = crc_reg;
    assign res_valid = res_valid_reg;
    assign fcs       = fcs_reg;
    assign fcs_ok    = fcs_ok_reg;
    assign runt      = runt_reg;
    assign keep_err  = keep_err_reg;
    assign frame_len = frame_len_reg;
    assign good_cnt  = good_reg;
    assign bad_cnt   = bad_reg;

endmodule

// File: tb/tb_eth_fcs_engine.sv
// -----------------------------------------------------------------------------
// tb_eth_fcs_engine
//
// Three engine instances: u0 (8-bit, MIN_LEN 0), u1 (32-bit, MIN_LEN 0) and
// u2 (64-bit, MIN_LEN 64). Frames are driven one at a time from a directed
// sequence; each completed frame pushes its expected result, tagged with the
// instance and the cycle res_valid must appear on, to a scoreboard queue that
// a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_eth_fcs_engine;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] crc;
        logic [31:0] fcs;
        logic        ok;
        logic        runt;
        logic        kerr;
        logic [15:0] len;
    } exp_t;

    localparam int NBY  [3] = '{1, 4, 8};
    localparam int MINL [3] = '{0, 0, 64};

    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;

    logic        v   [3];
    logic [63:0] d   [3];
    logic [7:0]  k   [3];
    logic        l   [3];
    logic        m   [3];
    logic        ab  [3];
    logic        cc  [3];

    logic [31:0] crc_o  [3];
    logic        rv_o   [3];
    logic [31:0] fcs_o  [3];
    logic        ok_o   [3];
    logic        runt_o [3];
    logic        ke_o   [3];
    logic [15:0] len_o  [3];
    logic [31:0] good_o [3];
    logic [31:0] bad_o  [3];

    exp_t exp_q[$];
    int   exp_good [3];
    int   exp_bad  [3];

    bq_t s9;
    bq_t s13;
    bq_t s13_bad;
    bq_t fr;

    eth_fcs_engine #(.DATA_W(8), .MIN_LEN(0)) u0 (
        .clk(clk), .rst(rst), .s_valid(v[0]), .s_data(d[0][7:0]), .s_keep(k[0][0:0]),
        .s_last(l[0]), .chk_mode(m[0]), .abort(ab[0]), .cnt_clr(cc[0]),
        .crc_cur(crc_o[0]), .res_valid(rv_o[0]), .fcs(fcs_o[0]), .fcs_ok(ok_o[0]),
        .runt(runt_o[0]), .keep_err(ke_o[0]), .frame_len(len_o[0]),
        .good_cnt(good_o[0]), .bad_cnt(bad_o[0])
    );

    eth_fcs_engine #(.DATA_W(32), .MIN_LEN(0)) u1 (
        .clk(clk), .rst(rst), .s_valid(v[1]), .s_data(d[1][31:0]), .s_keep(k[1][3:0]),
        .s_last(l[1]), .chk_mode(m[1]), .abort(ab[1]), .cnt_clr(cc[1]),
        .crc_cur(crc_o[1]), .res_valid(rv_o[1]), .fcs(fcs_o[1]), .fcs_ok(ok_o[1]),
        .runt(runt_o[1]), .keep_err(ke_o[1]), .frame_len(len_o[1]),
        .good_cnt(good_o[1]), .bad_cnt(bad_o[1])
    );

    eth_fcs_engine #(.DATA_W(64), .MIN_LEN(64)) u2 (
        .clk(clk), .rst(rst), .s_valid(v[2]), .s_data(d[2]), .s_keep(k[2]),
        .s_last(l[2]), .chk_mode(m[2]), .abort(ab[2]), .cnt_clr(cc[2]),
        .crc_cur(crc_o[2]), .res_valid(rv_o[2]), .fcs(fcs_o[2]), .fcs_ok(ok_o[2]),
        .runt(runt_o[2]), .keep_err(ke_o[2]), .frame_len(len_o[2]),
        .good_cnt(good_o[2]), .bad_cnt(bad_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bq_t str_q(input string s);
        bq_t q;
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Bitwise reference CRC-32 (reflected), returns the register before inversion.
    function automatic logic [31:0] crc_ref(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ q[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Drive one frame. first_n >= 0 forces the first beat to carry that many
    // bytes (a partial keep on a non-last beat). chk_mode is inverted on all
    // beats after the first to show it is latched per frame.
    task automatic send(input int inst, input bq_t f, input logic mode, input int first_n,
                        input logic do_abort, input logic do_clr, input logic b2b);
        int          idx;
        int          n;
        int          sz;
        logic [31:0] c;
        exp_t        e;
        logic        good;
        sz  = f.size();
        idx = 0;
        while (idx < sz) begin
            n = (sz - idx < NBY[inst]) ? (sz - idx) : NBY[inst];
            if (idx == 0 && first_n >= 0) n = first_n;
            d[inst] = {$urandom, $urandom};
            for (int j = 0; j < n; j++) d[inst][j*8 +: 8] = f[idx+j];
            k[inst]  = 8'((1 << n) - 1);
            l[inst]  = (idx + n >= sz);
            m[inst]  = (idx == 0) ? mode : ~mode;
            ab[inst] = do_abort && (idx + n >= sz);
            cc[inst] = do_clr && (idx + n >= sz);
            v[inst]  = 1'b1;
            @(posedge clk);
            #1;
            idx += n;
        end
        c      = crc_ref(f);
        e.inst = inst;
        e.due  = cyc;
        e.crc  = c;
        e.fcs  = ~c;
        e.ok   = mode ? (c == 32'hDEBB_20E3) : 1'b1;
        e.len  = 16'(sz);
        e.runt = (sz < MINL[inst]);
        e.kerr = (first_n >= 0);
        good   = e.ok && !e.runt && !e.kerr;
        if (!do_abort) exp_q.push_back(e);
        if (do_clr) begin
            exp_good[inst] = 0;
            exp_bad[inst]  = 0;
        end else if (!do_abort) begin
            if (good) exp_good[inst]++;
            else      exp_bad[inst]++;
        end
        if (!b2b) begin
            v[inst]  = 1'b0;
            l[inst]  = 1'b0;
            ab[inst] = 1'b0;
            cc[inst] = 1'b0;
        end
    endtask

    task automatic chk_cnt(input int inst);
        chk($sformatf("u%0d_good_cnt", inst), good_o[inst], exp_good[inst]);
        chk($sformatf("u%0d_bad_cnt", inst), bad_o[inst], exp_bad[inst]);
    endtask

    // -------------------------------------------------------------------------
    // Result monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                chk($sformatf("u%0d_res_missing", exp_q[0].inst), rv_o[exp_q[0].inst], 1'b1);
                void'(exp_q.pop_front());
            end
            for (int i = 0; i < 3; i++) begin
                if (rv_o[i] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("u%0d_res_unexpected", i), rv_o[i], 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("res u%0d cyc %0d: fcs=%h ok=%b runt=%b kerr=%b len=%0d",
                                 i, cyc, fcs_o[i], ok_o[i], runt_o[i], ke_o[i], len_o[i]);
                        chk($sformatf("u%0d_res_inst", i), i, e.inst);
                        chk($sformatf("u%0d_res_cycle", i), cyc, e.due);
                        chk($sformatf("u%0d_crc_cur", i), crc_o[i], e.crc);
                        chk($sformatf("u%0d_fcs", i), fcs_o[i], e.fcs);
                        chk($sformatf("u%0d_fcs_ok", i), ok_o[i], e.ok);
                        chk($sformatf("u%0d_runt", i), runt_o[i], e.runt);
                        chk($sformatf("u%0d_keep_err", i), ke_o[i], e.kerr);
                        chk($sformatf("u%0d_frame_len", i), len_o[i], e.len);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] c;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; d[i] = '0; k[i] = '0; l[i] = 1'b0;
            m[i] = 1'b0; ab[i] = 1'b0; cc[i] = 1'b0;
            exp_good[i] = 0; exp_bad[i] = 0;
        end

        s9      = str_q("123456789");
        s13     = s9;
        s13.push_back(8'h26); s13.push_back(8'h39); s13.push_back(8'hF4); s13.push_back(8'hCB);
        s13_bad = s13;
        s13_bad[0] = s13_bad[0] ^ 8'h04;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_rst_crc_cur", i), crc_o[i], 32'hFFFF_FFFF);
            chk($sformatf("u%0d_rst_res_valid", i), rv_o[i], 1'b0);
            chk($sformatf("u%0d_rst_fcs", i), fcs_o[i], 32'd0);
            chk($sformatf("u%0d_rst_fcs_ok", i), ok_o[i], 1'b0);
            chk($sformatf("u%0d_rst_runt", i), runt_o[i], 1'b0);
            chk($sformatf("u%0d_rst_keep_err", i), ke_o[i], 1'b0);
            chk($sformatf("u%0d_rst_frame_len", i), len_o[i], 16'd0);
            chk_cnt(i);
        end

        // Generate, 8-bit, "123456789"
        send(0, s9, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        chk("u0_gen_fcs_const", fcs_o[0], 32'hCBF4_3926);
        chk("u0_gen_crc_const", crc_o[0], 32'h340B_C6D9);
        chk("u0_gen_ok_const", ok_o[0], 1'b1);
        chk("u0_gen_len_const", len_o[0], 16'd9);
        chk("u0_gen_good_const", good_o[0], 32'd1);
        chk_cnt(0);
        repeat (2) @(posedge clk);
        #1;
        chk("u0_res_valid_one_cycle", rv_o[0], 1'b0);

        // Check, 32-bit, 4/4/4/1 beats with good FCS, then one bit corrupted
        send(1, s13, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("u1_chk_ok_const", ok_o[1], 1'b1);
        chk("u1_chk_len_const", len_o[1], 16'd13);
        chk_cnt(1);
        @(posedge clk); #1;
        send(1, s13_bad, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("u1_chk_bad_ok_const", ok_o[1], 1'b0);
        chk("u1_chk_bad_cnt_const", bad_o[1], 32'd1);
        chk_cnt(1);
        @(posedge clk); #1;

        // 64-bit, 60-byte check frame with valid FCS but below MIN_LEN
        fr = {};
        for (int i = 0; i < 56; i++) fr.push_back(8'($urandom));
        c = ~crc_ref(fr);
        fr.push_back(c[7:0]); fr.push_back(c[15:8]); fr.push_back(c[23:16]); fr.push_back(c[31:24]);
        send(2, fr, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("u2_runt_const", runt_o[2], 1'b1);
        chk("u2_ok_const", ok_o[2], 1'b1);
        chk("u2_bad_cnt_const", bad_o[2], 32'd1);
        chk_cnt(2);
        @(posedge clk); #1;

        // Back-to-back: generate frame then corrupted check frame, no gap
        send(1, s9, 1'b0, -1, 1'b0, 1'b0, 1'b1);
        send(1, s13_bad, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        chk("u1_b2b_ok_const", ok_o[1], 1'b0);
        chk_cnt(1);
        @(posedge clk); #1;

        // Abort together with the last beat, then a clean frame
        send(0, s9, 1'b0, -1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_cnt(0);
        chk("u0_abort_crc_reseed", crc_o[0], 32'hFFFF_FFFF);
        send(0, s9, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        chk("u0_after_abort_fcs_const", fcs_o[0], 32'hCBF4_3926);
        chk_cnt(0);
        @(posedge clk); #1;

        // Keep 0x3 on a non-last beat
        fr = str_q("0123456789");
        send(1, fr, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        chk("u1_keep_err_const", ke_o[1], 1'b1);
        chk_cnt(1);
        @(posedge clk); #1;

        // Counter clear coinciding with a good frame's increment
        send(1, s9, 1'b0, -1, 1'b0, 1'b1, 1'b0);
        chk("u1_clr_good_const", good_o[1], 32'd0);
        chk_cnt(1);
        @(posedge clk); #1;
        send(1, s9, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        chk("u1_after_clr_good_const", good_o[1], 32'd1);
        chk_cnt(1);

        // Reset mid-frame clears the frame and the counters
        v[2] = 1'b1; k[2] = 8'hFF; l[2] = 1'b0; d[2] = {$urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b1;
        v[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_good[i] = 0;
            exp_bad[i]  = 0;
            chk_cnt(i);
            chk($sformatf("u%0d_reset_crc_cur", i), crc_o[i], 32'hFFFF_FFFF);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
